// File: rtl/demux_rr_1ton_if.sv
// Sample bus between a producer and the round-robin demux: one sample in, N channel fields out.
interface demux_rr_1ton_if #(
  parameter int BW = 6,
  parameter int N  = 4
);
  localparam int W  = BW + 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic signed [W-1:0]   IN;
  logic                  IN_VLD;
  logic                  SYNC;
  logic [N*W-1:0]        OUT;
  logic                  OUT_VLD;
  logic [CW-1:0]         CH;

  modport master (output IN, IN_VLD, SYNC, input OUT, OUT_VLD, CH);
  modport slave  (input IN, IN_VLD, SYNC, output OUT, OUT_VLD, CH);
endinterface

// File: rtl/demux_rr_1ton.sv
// Round-robin 1:N sample demux with optional frame-aligned output update; 1-cycle latency.
// No backpressure: every IN_VLD cycle is a sample taken, SYNC restarts the frame at slot 0.
module demux_rr_1ton #(
  parameter int BW    = 6,
  parameter int N     = 4,
  parameter int ALIGN = 1
) (
  input  logic             CLK,
  input  logic             RES_B,
  demux_rr_1ton_if.slave   bus
);
  localparam int W  = BW + 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         slot;
  logic [N-1:0][W-1:0]   out_q, out_d;
  logic [N-2:0][W-1:0]   shadow_q, shadow_d;
  logic                  vld_q, vld_d;

  always_comb begin
    ptr_d    = ptr_q;
    out_d    = out_q;
    shadow_d = shadow_q;
    vld_d    = 1'b0;
    // SYNC with a sample forces that sample into slot 0 whatever the pointer held.
    slot     = bus.SYNC ? '0 : ptr_q;

    if (bus.IN_VLD) begin
      ptr_d = (slot == CW'(N-1)) ? '0 : slot + CW'(1);
      vld_d = (slot == CW'(N-1));
      if (ALIGN == 0) begin
        for (int k = 0; k < N; k++) begin
          if (slot == CW'(k)) out_d[k] = bus.IN;
        end
      end else begin
        for (int k = 0; k < N-1; k++) begin
          if (slot == CW'(k)) shadow_d[k] = bus.IN;
        end
        if (slot == CW'(N-1)) begin
          for (int j = 0; j < N-1; j++) out_d[j] = shadow_q[j];
          out_d[N-1] = bus.IN;
        end
      end
    end else if (bus.SYNC) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RES_B) begin
    if (!RES_B) begin
      ptr_q    <= '0;
      out_q    <= '0;
      shadow_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      shadow_q <= shadow_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.OUT     = out_q;
  assign bus.OUT_VLD = vld_q;
  assign bus.CH      = ptr_q;
endmodule
